rib_mem_responder: RTL and testbench
====================================

# rib_mem_responder

Word-addressed RIB bus responder: the target-side end of the request/ready handshake that the core's data port (`rib_ex_*`) drives. It holds a local RAM of DEPTH 32-bit words and answers each request after a programmable number of wait states. Read data and an access-fault flag return in the `ready` cycle. It sits behind the RIB interconnect as a data RAM or scratchpad, and it doubles as a latency-injecting memory model for core verification.

## Interface
Parameters:
- `DEPTH`, default 4096: number of 32-bit words; power of two, ≥ 2.
- `BASE_ADDR`, default 32'h1000_0000: byte address of word 0; aligned to DEPTH*4.
- `LATENCY`, default 0: wait-state cycles inserted between request capture and `ready`; range 0..15.

Ports (one clock; reset is synchronous and active-low):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous active-low reset.
- `req_i`  in  1  access request from initiator.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  MemAddrBus  byte address.
- `wdata_i`  in  MemBus  write data.
- `ready_o`  out  1  one-cycle response strobe.
- `rdata_o`  out  MemBus  read data; valid when `ready_o`=1.
- `err_o`  out  1  access fault; valid when `ready_o`=1.
- `busy_o`  out  1  a transfer has been accepted and not yet completed.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When `req_i`=1, capture `we_i`, `addr_i` and `wdata_i` into request registers.
  - Go to WAIT if LATENCY>0 (load the down-counter with LATENCY−1); otherwise go to RESP.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- RESP: `ready_o`=1 for exactly one cycle, then return to IDLE. `req_i` is ignored in RESP.
- Decode is done on the captured address. `err_o`=1 if `addr[1:0]`≠0 or addr ∉ [BASE_ADDR, BASE_ADDR+DEPTH*4).
- Word index = (addr−BASE_ADDR)[log2(DEPTH)+1:2].
- Read: `rdata_o` = mem[index] in RESP. On `err_o`, `rdata_o`=0.
- Write: mem[index] is updated at the clock edge that ends RESP. On `err_o` the write is dropped. `rdata_o`=0 for writes.
- The initiator holds `req_i`/`addr_i`/`we_i`/`wdata_i` stable until it samples `ready_o`=1. Inputs that change after capture are ignored.
- `busy_o` = (state≠IDLE).

## Timing
- Reset values: state IDLE, `ready_o`=0, `err_o`=0, `rdata_o`=0, `busy_o`=0, counter 0. RAM contents are not cleared.
- Latency: `req_i` sampled high at edge t gives `ready_o`=1 during cycle t+1+LATENCY.
- Throughput: one transfer per LATENCY+2 cycles. A `req_i` still high in the cycle after RESP starts a new transfer.
- `rdata_o` and `err_o` are registered. They hold their last values after RESP until the next RESP, but are only meaningful with `ready_o`.
- Read-after-write to the same word in back-to-back transfers returns the new data.
- Reset asserted mid-transfer (WAIT or RESP): next state IDLE, `ready_o`=0. A write pending in WAIT is discarded. A write in RESP at the reset edge is also discarded.
- `req_i` deasserted during WAIT (protocol violation): the transfer still completes with a `ready_o` pulse.

## Structure
- `tinyriscv_pkg` holds `typedef enum logic [1:0] {RESP_IDLE, RESP_WAIT, RESP_RESP} rib_resp_state_e`, plus the reuse of `MemAddrBus`/`MemBus`.
- Sub-module `rib_mem_array`: synchronous single-port RAM (DEPTH×32; write enable, index, wdata, registered rdata). The FSM, counter and decode stay in the top-level module.

## Test plan
- LATENCY=0: write 32'hDEAD_BEEF to BASE_ADDR+8, then read it → `ready_o` one cycle after each request, read `rdata_o`=32'hDEAD_BEEF, `err_o`=0.
- LATENCY=3: read with `req_i` held → `ready_o` exactly 4 cycles after the capture edge, `busy_o` high for 4 cycles. A held `req_i` re-captures on the cycle after `ready_o`.
- Fault cases, each giving `ready_o`=1, `err_o`=1, `rdata_o`=0:
  - Write to BASE_ADDR+DEPTH*4 → a subsequent read of word 0 is unchanged.
  - Access to BASE_ADDR+2 (misaligned).
- Back-to-back write of 32'h1234_5678 then read of the same word, LATENCY=0 → read returns 32'h1234_5678. Transfers are spaced 2 cycles apart.
- `rst_ni` pulled low during WAIT of a write (LATENCY=5) → `ready_o` never pulses, the word keeps its old value, state returns to IDLE.
- Change `addr_i`/`wdata_i` during WAIT → the response uses the captured values.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared bus types and the RIB memory responder state encoding.
package tinyriscv_pkg;

    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemBus;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_WAIT,
        RESP_RESP
    } rib_resp_state_e;

endpackage

// File: rtl/rib_mem_array.sv
// Synchronous single-port word RAM with registered read data.
module rib_mem_array
    import tinyriscv_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] idx_i,
    input  MemBus         wdata_i,
    output MemBus         rdata_o
);

    MemBus mem [DEPTH];
    MemBus rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rib_mem_responder.sv
// RIB target: local word RAM answering each request after LATENCY
// wait states, with access-fault decode on the captured address.
module rib_mem_responder
    import tinyriscv_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          LATENCY   = 0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      req_i,
    input  logic      we_i,
    input  MemAddrBus addr_i,
    input  MemBus     wdata_i,
    output logic      ready_o,
    output MemBus     rdata_o,
    output logic      err_o,
    output logic      busy_o
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    rib_resp_state_e state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    MemAddrBus       addr_q, addr_d;
    MemBus           wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            zero_q, zero_d;

    MemAddrBus       acc_addr;
    logic [31:0]     acc_off;
    logic            acc_we;
    logic            acc_err;
    logic [AW-1:0]   ram_idx;
    logic            ram_re;
    logic            ram_we;
    MemBus           ram_rdata;

    // With zero latency the RAM is read at the capture edge, so the
    // decode source is the live bus in IDLE and the captured copy after.
    always_comb begin
        acc_addr = (state_q == RESP_IDLE) ? addr_i : addr_q;
        acc_we   = (state_q == RESP_IDLE) ? we_i : we_q;
        acc_off  = acc_addr - BASE_ADDR;
        acc_err  = (acc_addr[1:0] != 2'b00) || (acc_off >= SPAN);
        ram_idx  = acc_off[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        zero_d  = zero_q;
        unique case (state_q)
            RESP_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (LATENCY > 0) begin
                        state_d = RESP_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = RESP_RESP;
                    end
                end
            end
            RESP_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP_RESP: begin
                state_d = RESP_IDLE;
            end
            default: begin
                state_d = RESP_IDLE;
            end
        endcase
        ram_re = (state_d == RESP_RESP);
        if (ram_re) begin
            err_d  = acc_err;
            zero_d = acc_err | acc_we;
        end
        ram_we = (state_q == RESP_RESP) && we_q && !err_q && rst_ni;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RESP_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    rib_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .idx_i   (ram_idx),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign ready_o = (state_q == RESP_RESP);
    assign busy_o  = (state_q != RESP_IDLE);
    assign err_o   = err_q;
    assign rdata_o = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_rib_mem_responder.sv
// Directed bench: three responders (LATENCY 0, 3, 5) on a shared bus.
module tb_rib_mem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          DEP  = 16;

    logic        clk;
    logic        rst_n;
    logic        req [3];
    logic        we_s;
    logic [31:0] addr_s;
    logic [31:0] wdata_s;
    logic        rdy [3];
    logic [31:0] rd  [3];
    logic        er  [3];
    logic        bsy [3];

    int nerr;
    int nchk;

    rib_mem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(0)) u_l0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we_s),
        .addr_i(addr_s), .wdata_i(wdata_s), .ready_o(rdy[0]),
        .rdata_o(rd[0]), .err_o(er[0]), .busy_o(bsy[0])
    );

    rib_mem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we_s),
        .addr_i(addr_s), .wdata_i(wdata_s), .ready_o(rdy[1]),
        .rdata_o(rd[1]), .err_o(er[1]), .busy_o(bsy[1])
    );

    rib_mem_responder #(.DEPTH(DEP), .BASE_ADDR(BASE), .LATENCY(5)) u_l5 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we_s),
        .addr_i(addr_s), .wdata_i(wdata_s), .ready_o(rdy[2]),
        .rdata_o(rd[2]), .err_o(er[2]), .busy_o(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transfer on responder k; tamper corrupts addr/wdata after capture.
    task automatic xfer(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit tamper,
                        output logic [31:0] r, output logic e,
                        output int lat, output int nb);
        @(negedge clk);
        req[k]  = 1'b1;
        we_s    = w;
        addr_s  = a;
        wdata_s = d;
        lat     = 0;
        nb      = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bsy[k]) nb++;
            if (rdy[k]) break;
            if (tamper && lat == 1) begin
                addr_s  = a + 32'd4;
                wdata_s = ~d;
            end
        end
        r      = rd[k];
        e      = er[k];
        req[k] = 1'b0;
        check("timeout", {31'b0, rdy[k]}, 32'd1);
    endtask

    task automatic run(input string tag, input int k, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit tamper, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat);
        logic [31:0] r;
        logic        e;
        int          lat;
        int          nb;
        xfer(k, w, a, d, tamper, r, e, lat, nb);
        check({tag, ".rd"}, r, exp_rd);
        check({tag, ".err"}, {31'b0, e}, {31'b0, exp_err});
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".busy"}, nb, exp_lat);
    endtask

    initial begin
        int cnt;
        nerr    = 0;
        nchk    = 0;
        rst_n   = 1'b0;
        we_s    = 1'b0;
        addr_s  = '0;
        wdata_s = '0;
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst.ready", {31'b0, rdy[k]}, 32'd0);
            check("rst.err", {31'b0, er[k]}, 32'd0);
            check("rst.rdata", rd[k], 32'd0);
            check("rst.busy", {31'b0, bsy[k]}, 32'd0);
        end
        rst_n = 1'b1;

        // Zero latency: basic write/read and back-to-back RAW.
        run("l0.wr8", 0, 1, BASE + 8, 32'hDEAD_BEEF, 0, 32'd0, 0, 1);
        run("l0.rd8", 0, 0, BASE + 8, 32'd0, 0, 32'hDEAD_BEEF, 0, 1);
        run("l0.wr12", 0, 1, BASE + 12, 32'h1234_5678, 0, 32'd0, 0, 1);
        run("l0.rd12", 0, 0, BASE + 12, 32'd0, 0, 32'h1234_5678, 0, 1);
        run("l0.wr0", 0, 1, BASE, 32'h0BAD_F00D, 0, 32'd0, 0, 1);
        run("l0.wr60", 0, 1, BASE + 60, 32'hCAFE_0060, 0, 32'd0, 0, 1);
        run("l0.rd60", 0, 0, BASE + 60, 32'd0, 0, 32'hCAFE_0060, 0, 1);

        // Faults: past the end, below base, misaligned.
        run("l0.wrend", 0, 1, BASE + 64, 32'hFFFF_FFFF, 0, 32'd0, 1, 1);
        run("l0.rdend", 0, 0, BASE + 64, 32'd0, 0, 32'd0, 1, 1);
        run("l0.rdlow", 0, 0, BASE - 4, 32'd0, 0, 32'd0, 1, 1);
        run("l0.rdmis", 0, 0, BASE + 2, 32'd0, 0, 32'd0, 1, 1);
        run("l0.wrmis", 0, 1, BASE + 2, 32'h7777_7777, 0, 32'd0, 1, 1);
        run("l0.rd0", 0, 0, BASE, 32'd0, 0, 32'h0BAD_F00D, 0, 1);

        // LATENCY=3, including captured values surviving bus changes.
        run("l3.wr8", 1, 1, BASE + 8, 32'h2222_2222, 0, 32'd0, 0, 4);
        run("l3.wr12", 1, 1, BASE + 12, 32'h3333_3333, 0, 32'd0, 0, 4);
        run("l3.rdtamp", 1, 0, BASE + 8, 32'd0, 1, 32'h2222_2222, 0, 4);
        run("l3.wrtamp", 1, 1, BASE + 16, 32'h4444_4444, 1, 32'd0, 0, 4);
        run("l3.rd16", 1, 0, BASE + 16, 32'd0, 0, 32'h4444_4444, 0, 4);
        run("l3.rd20", 1, 0, BASE + 20, 32'd0, 0, 32'd0, 0, 4);
        run("l3.rdmis", 1, 0, BASE + 9, 32'd0, 0, 32'd0, 1, 4);

        // Held request re-captures in the cycle after ready.
        @(negedge clk);
        req[1] = 1'b1;
        we_s   = 1'b0;
        addr_s = BASE + 12;
        cnt    = 0;
        while (cnt < 40 && !rdy[1]) begin
            @(negedge clk);
            cnt++;
        end
        check("hold.lat1", cnt, 32'd4);
        check("hold.rd1", rd[1], 32'h3333_3333);
        @(negedge clk);
        check("hold.idle.rdy", {31'b0, rdy[1]}, 32'd0);
        check("hold.idle.busy", {31'b0, bsy[1]}, 32'd0);
        @(negedge clk);
        check("hold.recap.busy", {31'b0, bsy[1]}, 32'd1);
        cnt = 0;
        while (cnt < 40 && !rdy[1]) begin
            @(negedge clk);
            cnt++;
        end
        check("hold.lat2", cnt, 32'd3);
        check("hold.rd2", rd[1], 32'h3333_3333);
        req[1] = 1'b0;

        // LATENCY=5: reset during WAIT of a write discards it.
        run("l5.wr20", 2, 1, BASE + 20, 32'hAAAA_0005, 0, 32'd0, 0, 6);
        @(negedge clk);
        req[2]  = 1'b1;
        we_s    = 1'b1;
        addr_s  = BASE + 20;
        wdata_s = 32'h5555_5555;
        repeat (2) @(negedge clk);
        check("l5.wait.busy", {31'b0, bsy[2]}, 32'd1);
        rst_n  = 1'b0;
        req[2] = 1'b0;
        @(negedge clk);
        check("l5.rst.busy", {31'b0, bsy[2]}, 32'd0);
        check("l5.rst.rdy", {31'b0, rdy[2]}, 32'd0);
        check("l5.rst.rdata", rd[2], 32'd0);
        rst_n = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy[2]) cnt++;
        end
        check("l5.noready", cnt, 32'd0);
        run("l5.rd20", 2, 0, BASE + 20, 32'd0, 0, 32'hAAAA_0005, 0, 6);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
